vga_scan_ctrl: RTL
==================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel clocks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter SYNC_DLY, 2, pipeline delay in clocks applied to hsync_n/vsync_n/blank_n.
REQ-006 Port clk  input  1  25 MHz pixel clock, single clock domain.
REQ-007 Port resetn  input  1  asynchronous active-low reset.
REQ-008 Port field_in  input  400  live 20x20 playfield from game logic, bit y*20+x.
REQ-009 Port field_out  output  400  frame-stable playfield snapshot fed to the display stage.
REQ-010 Port ADDR  output  19  linear pixel address y*640+x of the current visible pixel.
REQ-011 Port hcount  output  10  current horizontal position, 0..799.
REQ-012 Port vcount  output  10  current vertical position, 0..524.
REQ-013 Port hsync_n  output  1  active-low horizontal sync, delayed SYNC_DLY.
REQ-014 Port vsync_n  output  1  active-low vertical sync, delayed SYNC_DLY.
REQ-015 Port blank_n  output  1  high when delayed position is visible.
REQ-016 Port frame_start  output  1  one-clock pulse at (hcount,vcount)=(0,0).
REQ-017 Port vblank_start  output  1  one-clock pulse at (0,V_ACTIVE).

Function
REQ-018 hcount SHALL increment every clock and wrap from H_TOTAL-1 (799) to 0.
REQ-019 vcount SHALL increment only on the hcount wrap and wrap from V_TOTAL-1 (524) to 0; (799,524) SHALL go to (0,0).
REQ-020 ADDR SHALL equal vcount*640+hcount combinationally-consistent with the registered counters while visible (hcount<640, vcount<480), via an incrementing 19-bit register, not a multiplier.
REQ-021 ADDR SHALL hold its last value outside the visible area and SHALL be 0 in the cycle where counters read (0,0).
REQ-022 Undelayed hsync SHALL be asserted for hcount in 656..751; undelayed vsync for vcount in 490..491; both low-true.
REQ-023 hsync_n, vsync_n, blank_n SHALL be their undelayed values passed through a SYNC_DLY-stage shift register, aligning them with the registered colour of the downstream display stage.
REQ-024 field_out SHALL load field_in in the single cycle where counters read (0,480) and hold otherwise, so no visible pixel of a frame sees a field change.
REQ-025 frame_start and vblank_start SHALL be registered one-clock pulses coincident with the counter values they name.
REQ-026 SYNC_DLY=0 SHALL yield undelayed sync/blank outputs.

Reset
REQ-027 While resetn=0: hcount=0, vcount=0, ADDR=0, field_out=0, frame_start=0, vblank_start=0, hsync_n=1, vsync_n=1, blank_n=0 including all delay stages.
REQ-028 Reset asserted mid-frame SHALL take effect immediately; after release, first cycle presents (0,0) with frame_start=1.

Structure
REQ-029 VGA timing constants (H/V active, porch, sync, totals) SHALL live in a shared timing header used by this block and the display stage.
REQ-030 The sync/blank delay line SHALL be a sub-module named sync_delay_line, parameterised by width and depth.

Verification
REQ-031 Release reset, run 2 frames -> 420000 clocks per frame, frame_start every 420000 clocks, first at cycle 0 after release.
REQ-032 Line 0 -> hsync_n low for exactly 96 clocks starting at hcount 656+SYNC_DLY; blank_n high for 640 clocks.
REQ-033 Visible pixel (x=639,y=479) -> ADDR=307199; next visible pixel after wrap (0,0) -> ADDR=0.
REQ-034 Toggle field_in to 400'h1 at (100,200), then to 0 at (0,481) -> field_out stays 0 until (0,480), equals 1 after, unchanged by second toggle until next frame.
REQ-035 Assert resetn=0 at (300,250) for 3 clocks -> all outputs at reset values during the low; restart at (0,0) with frame_start pulse.

Source files
------------

// File: rtl/vga_scan_ctrl_pkg.sv
// Shared VGA 640x480@60 timing constants and sync bundle type, used by the
// scan controller and the downstream display stage.
package vga_scan_ctrl_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W   = 10;
  localparam int ADDR_W  = 19;
  localparam int FIELD_W = 400;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

  // True when c lies in [lo, lo+len).
  function automatic logic in_window(logic [CNT_W-1:0] c, int lo, int len);
    return (c >= CNT_W'(lo)) && (c < CNT_W'(lo + len));
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// Resettable WIDTH x DEPTH shift register; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pipe <= {DEPTH{RST_VAL}};
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: h/v counters, incrementing pixel address,
// delayed sync/blank, frame pulses and a per-frame playfield snapshot.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SYNC_DLY = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [FIELD_W-1:0] field_in,
  output logic [FIELD_W-1:0] field_out,
  output logic [ADDR_W-1:0]  ADDR,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               blank_n,
  output logic               frame_start,
  output logic               vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // started holds the counters at (0,0) for the first clock after reset so
  // that cycle can carry the frame_start pulse.
  logic             started;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             home_nxt, vis_nxt;
  sync_t            s_raw, s_dly;

  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (started) begin
      if (hcount == CNT_W'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (vcount == CNT_W'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
  end

  assign home_nxt = (h_nxt == '0) && (v_nxt == '0);
  assign vis_nxt  = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started      <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      ADDR         <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      field_out    <= '0;
    end else begin
      started      <= 1'b1;
      hcount       <= h_nxt;
      vcount       <= v_nxt;
      frame_start  <= home_nxt;
      vblank_start <= (h_nxt == '0) && (v_nxt == CNT_W'(V_ACTIVE));
      // Address only advances on visible pixels, so it already holds
      // y*H_ACTIVE-1 when the next visible line begins.
      if (home_nxt)     ADDR <= '0;
      else if (vis_nxt) ADDR <= ADDR + 1'b1;
      if (hcount == '0 && vcount == CNT_W'(V_ACTIVE)) field_out <= field_in;
    end
  end

  always_comb begin
    s_raw.hsync_n = !in_window(hcount, H_ACTIVE + H_FP, H_SYNC);
    s_raw.vsync_n = !in_window(vcount, V_ACTIVE + V_FP, V_SYNC);
    s_raw.blank_n = started && (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
  end

  sync_delay_line #(
    .WIDTH  ($bits(sync_t)),
    .DEPTH  (SYNC_DLY),
    .RST_VAL(SYNC_RST)
  ) u_sync_dly (
    .clk   (clk),
    .resetn(resetn),
    .d     (s_raw),
    .q     (s_dly)
  );

  assign hsync_n = s_dly.hsync_n;
  assign vsync_n = s_dly.vsync_n;
  assign blank_n = s_dly.blank_n;
endmodule
